// File: rtl/fphub_pkg.sv
// Shared types for the FPHUB adder arbiter.
// - Default word geometry (1 sign + 8 exponent + 24 mantissa bits).
// - Arbiter FSM state encoding.
package fphub_pkg;

  localparam int unsigned DefaultExpW  = 8;
  localparam int unsigned DefaultMantW = 24;
  localparam int unsigned W            = DefaultExpW + DefaultMantW + 1;

  typedef logic [W-1:0] fphub_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } arb_state_t;

endpackage

// File: rtl/fphub_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i       requester valid vector
//   ptr_i       highest-priority index this round
//   gnt_o       one-hot grant (first set bit at or after ptr_i, wrapping)
//   gnt_idx_o   encoded index of gnt_o
//   gnt_valid_o any request present
module fphub_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]  gnt_idx_o,
  output logic             gnt_valid_o
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found     = 1'b0;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr_i) + off) % N_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PtrW'(idx);
      end
    end
  end

  assign gnt_valid_o = |req_i;

endmodule

// File: rtl/fphub_add_arbiter.sv
// Shares one external FPHUB adder between N_REQ requesters, one operation at a time.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is the one-hot grant, only in idle
//   req_x, req_y          packed operand words, slice i = [i*W +: W]
//   rsp_valid/rsp_ready   one-hot response handshake toward the granted requester
//   rsp_z                 captured sum
//   add_x, add_y, add_z   adder operand outputs and sum input
//   busy                  high whenever an operation is in flight or awaiting acceptance
module fphub_add_arbiter
  import fphub_pkg::*;
#(
  parameter int unsigned M       = 24,
  parameter int unsigned E       = 8,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*(E+M+1)-1:0] req_x,
  input  logic [N_REQ*(E+M+1)-1:0] req_y,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [E+M:0]             rsp_z,
  output logic [E+M:0]             add_x,
  output logic [E+M:0]             add_y,
  input  logic [E+M:0]             add_z,
  output logic                     busy
);

  localparam int unsigned WordW = E + M + 1;
  localparam int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW  = $clog2(ADD_LAT + 1);

  arb_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]    gnt_id_q, gnt_id_d;
  logic [WordW-1:0]   op_x_q, op_x_d;
  logic [WordW-1:0]   op_y_q, op_y_d;
  logic [WordW-1:0]   rsp_z_q, rsp_z_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PtrW-1:0]    arb_idx;
  logic               arb_valid;

  fphub_rr_arbiter #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    op_x_d   = op_x_q;
    op_y_d   = op_y_q;
    rsp_z_d  = rsp_z_q;
    unique case (state_q)
      StIdle: begin
        // req_ready equals the grant here, so any valid request handshakes this edge.
        if (arb_valid) begin
          op_x_d   = req_x[32'(arb_idx)*WordW +: WordW];
          op_y_d   = req_y[32'(arb_idx)*WordW +: WordW];
          gnt_id_d = arb_idx;
          cnt_d    = CntW'(ADD_LAT);
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // Operands reach the adder one edge after the handshake, so the sum is
        // valid ADD_LAT edges later; count down to zero, then capture.
        if (cnt_q == '0) begin
          rsp_z_d = add_z;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready[gnt_id_q]) begin
          rr_ptr_d = PtrW'((32'(gnt_id_q) + 1) % N_REQ);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      op_x_q   <= '0;
      op_y_q   <= '0;
      rsp_z_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      op_x_q   <= op_x_d;
      op_y_q   <= op_y_d;
      rsp_z_q  <= rsp_z_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) rsp_valid[gnt_id_q] = 1'b1;
  end

  assign req_ready = (state_q == StIdle) ? arb_gnt : '0;
  assign busy      = (state_q != StIdle);
  // Operand registers only load on a handshake, so the adder inputs stay quiet otherwise.
  assign add_x     = op_x_q;
  assign add_y     = op_y_q;
  assign rsp_z     = rsp_z_q;

endmodule
